// File: rtl/bias_act_pkg.sv
// Shared encodings, constants and the fp32 activation helper for the bias/activation stream.
package bias_act_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

  localparam logic [31:0] FP32_SIX  = 32'h40C0_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // Activation by integer compare on the fp32 bit pattern. For non-negative
  // values the magnitude bits order like unsigned integers, so no fp comparator
  // is needed. A positive NaN compares above any finite bound and is clamped.
  function automatic logic [31:0] act_fp32(input logic [31:0] x,
                                           input act_mode_e   mode,
                                           input logic [31:0] c);
    logic [31:0] lim;
    logic [31:0] y;
    lim = (mode == ACT_CLAMP) ? c : FP32_SIX;
    y   = x;
    case (mode)
      ACT_NONE: y = x;
      ACT_RELU: y = x[31] ? FP32_ZERO : x;
      default:  y = x[31] ? FP32_ZERO : ((x[30:0] >= lim[30:0]) ? lim : x);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/bias_act_lane.sv
// One fp32 lane: (bias + shortcut) + data, then the activation register.
module bias_act_lane
  import bias_act_pkg::*;
#(
  parameter int FP_ADD_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic [31:0] bias_i,
  input  logic [31:0] sc_i,
  input  act_mode_e   mode_i,
  input  logic [31:0] clamp_i,
  output logic [31:0] y_o
);

  logic [31:0] sum_a, sum_b;
  logic [31:0] data_dly_q [FP_ADD_LAT];
  logic [31:0] y_q;

  fp_add #(.LAT(FP_ADD_LAT)) u_add_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_i    (bias_i),
    .b_i    (sc_i),
    .y_o    (sum_a)
  );

  // Hold data back so it meets the first sum at the second adder.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FP_ADD_LAT; i++) data_dly_q[i] <= 32'd0;
    end else begin
      data_dly_q[0] <= data_i;
      for (int i = 1; i < FP_ADD_LAT; i++) data_dly_q[i] <= data_dly_q[i-1];
    end
  end

  fp_add #(.LAT(FP_ADD_LAT)) u_add_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_i    (sum_a),
    .b_i    (data_dly_q[FP_ADD_LAT-1]),
    .y_o    (sum_b)
  );

  // Activation stage, using the mode/clamp that travelled with this beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) y_q <= 32'd0;
    else         y_q <= act_fp32(sum_b, mode_i, clamp_i);
  end

  assign y_o = y_q;

endmodule

// File: rtl/fp_add.sv
// Pipelined fp32 adder: round-to-nearest-even, subnormal inputs/outputs flushed to zero.
module fp_add #(
  parameter int LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [31:0] big, sml, sum_c;
  logic [7:0]  eb, es, ediff;
  logic [26:0] mb, ms, ms_sh, mask;
  logic [27:0] acc;
  logic [9:0]  e;
  logic [4:0]  sh;
  logic [24:0] rnd;
  logic        sgn, up;
  logic [31:0] res_q [LAT];

  // Full add in one combinational step; the result then rides LAT registers.
  always_comb begin
    big = a_i;
    sml = b_i;
    if (b_i[30:0] > a_i[30:0]) begin
      big = b_i;
      sml = a_i;
    end
    eb    = big[30:23];
    es    = sml[30:23];
    mb    = (eb == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    ms    = (es == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    ediff = eb - es;
    mask  = 27'd0;
    ms_sh = 27'd0;
    if (ediff > 8'd26) begin
      ms_sh = (ms != 27'd0) ? 27'd1 : 27'd0;
    end else begin
      mask     = (27'd1 << ediff) - 27'd1;
      ms_sh    = ms >> ediff;
      ms_sh[0] = ms_sh[0] | (|(ms & mask));
    end
    sgn   = big[31];
    e     = {2'b00, eb};
    acc   = 28'd0;
    sh    = 5'd0;
    rnd   = 25'd0;
    up    = 1'b0;
    sum_c = 32'd0;
    if (eb == 8'hFF) begin
      // NaN dominates; inf - inf is NaN; otherwise the infinity wins.
      if (big[22:0] != 23'd0)                        sum_c = 32'h7FC0_0000;
      else if (es == 8'hFF && sml[31] != big[31])    sum_c = 32'h7FC0_0000;
      else                                           sum_c = big;
    end else if (eb == 8'd0) begin
      sum_c = {big[31] & sml[31], 31'd0};
    end else begin
      if (big[31] == sml[31]) begin
        acc = {1'b0, mb} + {1'b0, ms_sh};
        if (acc[27]) begin
          acc = {1'b0, acc[27:2], acc[1] | acc[0]};
          e   = e + 10'd1;
        end
      end else begin
        acc = {1'b0, mb} - {1'b0, ms_sh};
      end
      if (acc == 28'd0) begin
        sum_c = 32'd0;
      end else begin
        // Highest set bit wins because the loop runs upward.
        for (int i = 0; i < 27; i++) begin
          if (acc[i]) sh = 5'(26 - i);
        end
        if ({5'd0, sh} >= e) begin
          sum_c = {sgn, 31'd0};
        end else begin
          acc = acc << sh;
          e   = e - {5'd0, sh};
          up  = acc[2] & (acc[3] | acc[1] | acc[0]);
          rnd = {1'b0, acc[26:3]} + {24'd0, up};
          if (rnd[24]) begin
            e   = e + 10'd1;
            rnd = {1'b0, rnd[24:1]};
          end
          if (e >= 10'd255) sum_c = {sgn, 8'hFF, 23'd0};
          else              sum_c = {sgn, e[7:0], rnd[22:0]};
        end
      end
    end
  end

  // Latency pipeline behind the combinational adder.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) res_q[i] <= 32'd0;
    end else begin
      res_q[0] <= sum_c;
      for (int i = 1; i < LAT; i++) res_q[i] <= res_q[i-1];
    end
  end

  assign y_o = res_q[LAT-1];

endmodule

// File: rtl/bias_act_stream.sv
// Multi-lane bias + shortcut + activation stream with credit-guarded output FIFO.
module bias_act_stream
  import bias_act_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int FP_ADD_LAT  = 3,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic                 clk_calc,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [LANES*32-1:0]  data_in,
  input  logic [LANES*32-1:0]  bias_in,
  input  logic [LANES*32-1:0]  sc_in,
  input  logic                 sc_vld,
  input  logic [1:0]           act_mode,
  input  logic [31:0]          clamp_val,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANES*32-1:0]  data_out
);

  localparam int PIPE   = 2 * FP_ADD_LAT + 1;
  localparam int SB_LEN = 2 * FP_ADD_LAT;
  localparam int PTR_W  = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OFIFO_DEPTH + PIPE + 2);
  localparam int W      = LANES * 32;

  if (FP_ADD_LAT < 1 || OFIFO_DEPTH < 2 * FP_ADD_LAT + 2) begin : g_cfg_err
    $error("bias_act_stream: need FP_ADD_LAT >= 1 and OFIFO_DEPTH >= 2*FP_ADD_LAT+2");
  end

  logic             accept, fifo_wr, pop, head_load;
  logic [W-1:0]     data_op, bias_op, sc_op, act_res;
  logic [PIPE-1:0]  vld_q;
  act_mode_e        mode_q  [SB_LEN];
  logic [31:0]      clamp_q [SB_LEN];
  logic [CNT_W-1:0] inflight_q, inflight_d, mem_cnt_q, mem_cnt_d, occupancy;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             rdy_en_q, out_vld_q;
  logic [W-1:0]     data_out_q;
  logic [W-1:0]     mem_q [OFIFO_DEPTH];

  assign accept  = in_vld & in_rdy;
  assign fifo_wr = vld_q[PIPE-1];
  assign pop     = out_vld_q & out_rdy;
  // Refill the head register whenever it is empty or being consumed.
  assign head_load = (mem_cnt_q != '0) && (!out_vld_q || pop);

  // Operands only enter the datapath on an accepted beat.
  assign data_op = accept ? data_in : '0;
  assign bias_op = accept ? bias_in : '0;
  assign sc_op   = (accept && sc_vld) ? sc_in : '0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    bias_act_lane #(.FP_ADD_LAT(FP_ADD_LAT)) u_lane (
      .clk_i   (clk_calc),
      .rst_ni  (rst_n),
      .data_i  (data_op[gi*32 +: 32]),
      .bias_i  (bias_op[gi*32 +: 32]),
      .sc_i    (sc_op[gi*32 +: 32]),
      .mode_i  (mode_q[SB_LEN-1]),
      .clamp_i (clamp_q[SB_LEN-1]),
      .y_o     (act_res[gi*32 +: 32])
    );
  end

  // Beat valid and per-beat sideband travel alongside the lane pipelines.
  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < SB_LEN; i++) begin
        mode_q[i]  <= ACT_NONE;
        clamp_q[i] <= 32'd0;
      end
    end else begin
      vld_q      <= {vld_q[PIPE-2:0], accept};
      mode_q[0]  <= accept ? act_mode_e'(act_mode) : ACT_NONE;
      clamp_q[0] <= accept ? clamp_val : 32'd0;
      for (int i = 1; i < SB_LEN; i++) begin
        mode_q[i]  <= mode_q[i-1];
        clamp_q[i] <= clamp_q[i-1];
      end
    end
  end

  // Next-state for the in-flight and stored-entry counters.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !fifo_wr)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && fifo_wr) inflight_d = inflight_q - CNT_W'(1);
    mem_cnt_d = mem_cnt_q;
    if (fifo_wr && !head_load)      mem_cnt_d = mem_cnt_q + CNT_W'(1);
    else if (!fifo_wr && head_load) mem_cnt_d = mem_cnt_q - CNT_W'(1);
  end

  // Credits count everything queued (storage + head) plus beats still in the pipe.
  assign occupancy = mem_cnt_q + CNT_W'(out_vld_q) + inflight_q;
  assign in_rdy    = rdy_en_q && (occupancy < CNT_W'(OFIFO_DEPTH));

  // Storage array, written at the pipeline exit; no reset so it maps to RAM.
  always_ff @(posedge clk_calc) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= act_res;
  end

  // Counters, pointers and the registered-read head of the FIFO.
  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      inflight_q <= '0;
      mem_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      inflight_q <= inflight_d;
      mem_cnt_q  <= mem_cnt_d;
      if (fifo_wr)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (head_load) begin
        rd_ptr_q   <= (rd_ptr_q == PTR_W'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        data_out_q <= mem_q[rd_ptr_q];
        out_vld_q  <= 1'b1;
      end else if (pop) begin
        data_out_q <= '0;
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_bias_act_stream.sv
// Directed + randomized stream bench for bias_act_stream with a beat scoreboard.
module tb_bias_act_stream;

  localparam int LANES = 16;
  localparam int W     = LANES * 32;
  localparam int DEPTH = 8;

  logic          clk_calc  = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_vld    = 1'b0;
  logic          in_rdy;
  logic [W-1:0]  data_in   = '0;
  logic [W-1:0]  bias_in   = '0;
  logic [W-1:0]  sc_in     = '0;
  logic          sc_vld    = 1'b0;
  logic [1:0]    act_mode  = 2'd0;
  logic [31:0]   clamp_val = 32'd0;
  logic          out_vld;
  logic          out_rdy   = 1'b0;
  logic [W-1:0]  data_out;

  bias_act_stream #(.LANES(LANES), .FP_ADD_LAT(3), .OFIFO_DEPTH(DEPTH)) dut (
    .clk_calc  (clk_calc),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .data_in   (data_in),
    .bias_in   (bias_in),
    .sc_in     (sc_in),
    .sc_vld    (sc_vld),
    .act_mode  (act_mode),
    .clamp_val (clamp_val),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .data_out  (data_out)
  );

  always #5 clk_calc = ~clk_calc;

  int           checks   = 0;
  int           failures = 0;
  int           n_acc    = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] cur_exp  = '0;
  logic         stall_q  = 1'b0;
  logic [W-1:0] stall_data = '0;

  function automatic logic [W-1:0] rep(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [31:0] act_ref(input logic [31:0] x, input logic [1:0] m,
                                          input logic [31:0] c);
    logic [31:0] lim;
    lim = (m == 2'd3) ? c : 32'h40C0_0000;
    if (m == 2'd0) return x;
    if (x[31]) return 32'h0;
    if (m == 2'd1) return x;
    if (x[30:0] >= lim[30:0]) return lim;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge: score the handshakes of the coming posedge, then advance one cycle.
  task automatic tick();
    logic         acc, pop;
    logic [W-1:0] front;
    acc = in_vld & in_rdy;
    pop = out_vld & out_rdy;
    if (stall_q) chk("stable_under_stall", data_out, stall_data);
    if (pop) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL spurious_out_vld observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        chk("pop_data", data_out, front);
      end
    end
    if (acc) begin
      exp_q.push_back(cur_exp);
      n_acc++;
      chk_int("credit_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
    end
    stall_q    = out_vld & ~out_rdy;
    stall_data = data_out;
    @(posedge clk_calc);
    @(negedge clk_calc);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk_int({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int           lat, base, seen;
    logic [31:0]  t2_d [5];
    logic [31:0]  t2_e [5];
    logic [31:0]  x, c;
    logic [1:0]   m;

    // Reset state
    repeat (3) @(negedge clk_calc);
    chk_int("reset_in_rdy", 32'(in_rdy), 32'd0);
    chk_int("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_data_out", data_out, '0);
    rst_n = 1'b1;
    chk_int("rdy_before_first_edge", 32'(in_rdy), 32'd0);
    @(posedge clk_calc);
    @(negedge clk_calc);
    chk_int("rdy_after_release", 32'(in_rdy), 32'd1);

    // T1: 1.0 + 0.5 + 2.0 = 3.5, latency to out_vld
    bias_in = rep(32'h3F80_0000); sc_in = rep(32'h3F00_0000); sc_vld = 1'b1;
    data_in = rep(32'h4000_0000); act_mode = 2'd0; out_rdy = 1'b1; in_vld = 1'b1;
    cur_exp = rep(32'h4060_0000);
    tick();
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 30) begin
      tick();
      lat++;
    end
    chk_int("t1_latency", 32'(lat), 32'd8);
    chk("t1_data", data_out, rep(32'h4060_0000));
    drain("t1");

    // T1b: cancellation 1.0 - 0.5 - 0.25 = 0.25; then ReLU of 1.0 - 3.0
    in_vld = 1'b1;
    bias_in = rep(32'h3F80_0000); sc_in = rep(32'hBF00_0000); sc_vld = 1'b1;
    data_in = rep(32'hBE80_0000); act_mode = 2'd0; cur_exp = rep(32'h3E80_0000);
    tick();
    sc_vld = 1'b0; data_in = rep(32'hC040_0000); act_mode = 2'd1; cur_exp = rep(32'h0);
    tick();
    drain("t1b");

    // T2: ReLU6 per-lane pattern; sc_in nonzero but ignored because sc_vld=0
    t2_d = '{32'hBF80_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40F0_0000, 32'h8000_0000};
    t2_e = '{32'h0000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 32'h0000_0000};
    bias_in = '0; sc_in = rep(32'h3F80_0000); sc_vld = 1'b0; act_mode = 2'd2;
    for (int i = 0; i < LANES; i++) begin
      data_in[i*32 +: 32] = t2_d[i % 5];
      cur_exp[i*32 +: 32] = t2_e[i % 5];
    end
    in_vld = 1'b1;
    tick();
    drain("t2");

    // T3: per-beat mode/clamp, back to back
    in_vld = 1'b1; bias_in = '0; sc_vld = 1'b0; data_in = rep(32'h4020_0000);
    act_mode = 2'd3; clamp_val = 32'h4000_0000; cur_exp = rep(32'h4000_0000);
    tick();
    act_mode = 2'd1; clamp_val = 32'h3F80_0000; cur_exp = rep(32'h4020_0000);
    tick();
    act_mode = 2'd3; clamp_val = 32'h4080_0000; cur_exp = rep(32'h4020_0000);
    tick();
    act_mode = 2'd2; data_in = rep(32'hC020_0000); cur_exp = rep(32'h0);
    tick();
    drain("t3");

    // T4: backpressure fills exactly DEPTH credits
    out_rdy = 1'b0; in_vld = 1'b1; act_mode = 2'd0; sc_vld = 1'b0; bias_in = '0;
    base = n_acc;
    for (int k = 0; k < 30; k++) begin
      data_in = rep(32'h3F80_0000 + 32'(n_acc - base));
      cur_exp = data_in;
      tick();
    end
    chk_int("t4_accepted", 32'(n_acc - base), 32'd8);
    chk_int("t4_in_rdy_low", 32'(in_rdy), 32'd0);
    chk_int("t4_head_valid", 32'(out_vld), 32'd1);
    chk("t4_head_data", data_out, rep(32'h3F80_0000));
    drain("t4");
    chk_int("t4_in_rdy_back", 32'(in_rdy), 32'd1);

    // T5: random flow control and data against the reference
    for (int k = 0; k < 600; k++) begin
      in_vld  = 1'($urandom_range(0, 1));
      out_rdy = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      c = {1'b0, 8'($urandom_range(124, 130)), 23'($urandom)};
      act_mode = m; clamp_val = c; bias_in = '0; sc_vld = 1'b0;
      sc_in = rep(32'($urandom));
      for (int i = 0; i < LANES; i++) begin
        x = {1'($urandom), 8'($urandom_range(122, 132)), 23'($urandom)};
        data_in[i*32 +: 32] = x;
        cur_exp[i*32 +: 32] = act_ref(x, m, c);
      end
      tick();
    end
    drain("t5");

    // T6: reset with 3 queued and 5 in flight
    out_rdy = 1'b0; act_mode = 2'd0; data_in = rep(32'h4100_0000); cur_exp = data_in;
    base = n_acc;
    in_vld = 1'b1;
    while (n_acc - base < 3) tick();
    in_vld = 1'b0;
    repeat (10) tick();
    in_vld = 1'b1;
    while (n_acc - base < 8) tick();
    in_vld = 1'b0;
    chk_int("t6_head_before_reset", 32'(out_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_int("t6_out_vld_in_reset", 32'(out_vld), 32'd0);
    chk("t6_data_out_in_reset", data_out, '0);
    chk_int("t6_in_rdy_in_reset", 32'(in_rdy), 32'd0);
    exp_q.delete();
    stall_q = 1'b0;
    repeat (2) @(negedge clk_calc);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_vld) seen++;
      tick();
    end
    chk_int("t6_no_out_after_reset", 32'(seen), 32'd0);
    chk_int("t6_in_rdy_after", 32'(in_rdy), 32'd1);
    bias_in = rep(32'h3F80_0000); sc_in = rep(32'h3F00_0000); sc_vld = 1'b1;
    data_in = rep(32'h4000_0000); act_mode = 2'd0; cur_exp = rep(32'h4060_0000);
    in_vld = 1'b1;
    tick();
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
